// File: rtl/ccip_rdreq_tracker_if.sv
// rtl/ccip_rdreq_tracker_if.sv - snooped CCI-P C0 read request/response signals
interface ccip_rdreq_tracker_if #(
  parameter int MDATA_W = 16
);
  logic [MDATA_W-1:0] c0_tx_mdata;
  logic               c0_tx_rd_valid;
  logic               c0_tx_alm_full;
  logic [MDATA_W-1:0] c0_rx_mdata;
  logic               c0_rx_rd_valid;

  modport master (
    output c0_tx_mdata, c0_tx_rd_valid, c0_tx_alm_full,
    output c0_rx_mdata, c0_rx_rd_valid
  );

  modport slave (
    input c0_tx_mdata, c0_tx_rd_valid, c0_tx_alm_full,
    input c0_rx_mdata, c0_rx_rd_valid
  );
endinterface

// File: rtl/ccip_rdreq_tracker.sv
// rtl/ccip_rdreq_tracker.sv - C0 read request tracker: latency, dup/orphan/timeout/overrun events
module ccip_rdreq_tracker #(
  parameter int TAG_W         = 6,
  parameter int LAT_W         = 12,
  parameter int TIMEOUT       = 2000,
  parameter int ALMFULL_SLACK = 8
) (
  input  logic                    clk_i,
  input  logic                    sys_reset_i,
  input  logic                    enable_i,
  ccip_rdreq_tracker_if.slave     c0,
  output logic [TAG_W:0]          outstanding_o,
  output logic [LAT_W-1:0]        max_latency_o,
  output logic [3:0]              err_sticky_o,
  output logic                    evt_valid_o,
  output logic [1:0]              evt_code_o,
  output logic [TAG_W-1:0]        evt_tag_o,
  output logic                    evt_lost_o
);
  localparam int DEPTH = 2 ** TAG_W;
  localparam int RUN_W = 16;
  localparam logic [LAT_W-1:0] AGE_MAX     = '1;
  localparam logic [LAT_W-1:0] TIMEOUT_AGE = LAT_W'(TIMEOUT);
  localparam logic [RUN_W-1:0] RUN_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_BUSY_TO = 2'd2
  } entry_state_e;

  entry_state_e     state_q [DEPTH];
  entry_state_e     state_d [DEPTH];
  logic [LAT_W-1:0] age_q   [DEPTH];
  logic [LAT_W-1:0] age_d   [DEPTH];

  logic [TAG_W:0]   outstanding_q, outstanding_d;
  logic [LAT_W-1:0] max_latency_q, max_latency_d;
  logic [3:0]       err_sticky_q, err_sticky_d;
  logic             evt_valid_q, evt_valid_d;
  logic [1:0]       evt_code_q, evt_code_d;
  logic [TAG_W-1:0] evt_tag_q, evt_tag_d;
  logic             evt_lost_q, evt_lost_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             almfull_prev_q, almfull_prev_d;

  logic [TAG_W-1:0] tx_tag, rx_tag, to_tag;
  logic             req, rsp, rsp_clear, orphan, dup, req_accept, overrun;
  logic             to_any, to_multi;
  logic [DEPTH-1:0] to_hit;
  logic [RUN_W-1:0] run_next;
  logic [2:0]       cause_cnt;

  assign tx_tag = c0.c0_tx_mdata[TAG_W-1:0];
  assign rx_tag = c0.c0_rx_mdata[TAG_W-1:0];
  assign req    = enable_i & c0.c0_tx_rd_valid;
  assign rsp    = enable_i & c0.c0_rx_rd_valid;

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      state_d[i] = state_q[i];
      age_d[i]   = age_q[i];
    end
    to_hit     = '0;
    orphan     = rsp && (state_q[rx_tag] == ST_IDLE);
    rsp_clear  = rsp && (state_q[rx_tag] != ST_IDLE);
    // The response is applied before the request, so a same-tag pair re-arms the entry.
    dup        = req && (state_q[tx_tag] != ST_IDLE) && !(rsp_clear && (rx_tag == tx_tag));
    req_accept = req && !dup;

    if (enable_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (state_q[i] != ST_IDLE) begin
          age_d[i] = (age_q[i] == AGE_MAX) ? age_q[i] : age_q[i] + LAT_W'(1);
          if (state_q[i] == ST_BUSY && age_q[i] == TIMEOUT_AGE) begin
            state_d[i] = ST_BUSY_TO;
            to_hit[i]  = 1'b1;
          end
        end
      end
      if (rsp_clear) begin
        state_d[rx_tag] = ST_IDLE;
        age_d[rx_tag]   = '0;
        to_hit[rx_tag]  = 1'b0;
      end
      if (req_accept) begin
        state_d[tx_tag] = ST_BUSY;
        age_d[tx_tag]   = LAT_W'(1);
      end
    end
  end

  always_comb begin
    to_tag = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (to_hit[i]) to_tag = TAG_W'(i);
    end
    to_any   = |to_hit;
    to_multi = |(to_hit & (to_hit - DEPTH'(1)));
  end

  // The run counts requests made while almost-full was seen on the previous cycle.
  always_comb begin
    run_next       = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
    overrun        = req && almfull_prev_q && (run_next > RUN_W'(ALMFULL_SLACK));
    run_d          = run_q;
    almfull_prev_d = almfull_prev_q;
    if (enable_i) begin
      almfull_prev_d = c0.c0_tx_alm_full;
      if (!c0.c0_tx_alm_full)        run_d = '0;
      else if (req && almfull_prev_q) run_d = run_next;
    end
  end

  always_comb begin
    cause_cnt     = 3'(orphan) + 3'(dup) + 3'(to_any) + 3'(overrun);
    outstanding_d = outstanding_q + (TAG_W+1)'(req_accept) - (TAG_W+1)'(rsp_clear);
    max_latency_d = max_latency_q;
    if (rsp_clear && age_q[rx_tag] > max_latency_q) max_latency_d = age_q[rx_tag];
    err_sticky_d  = err_sticky_q | {overrun, to_any, orphan, dup};
    evt_lost_d    = evt_lost_q | (cause_cnt > 3'd1) | to_multi;
    evt_valid_d   = cause_cnt != 3'd0;
    evt_code_d    = 2'd3;
    evt_tag_d     = '0;
    if (orphan) begin
      evt_code_d = 2'd1;
      evt_tag_d  = rx_tag;
    end else if (dup) begin
      evt_code_d = 2'd0;
      evt_tag_d  = tx_tag;
    end else if (to_any) begin
      evt_code_d = 2'd2;
      evt_tag_d  = to_tag;
    end else if (!overrun) begin
      evt_code_d = 2'd0;
    end
  end

  always_ff @(posedge clk_i or posedge sys_reset_i) begin
    if (sys_reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_q[i] <= ST_IDLE;
        age_q[i]   <= '0;
      end
      outstanding_q  <= '0;
      max_latency_q  <= '0;
      err_sticky_q   <= '0;
      evt_valid_q    <= 1'b0;
      evt_code_q     <= '0;
      evt_tag_q      <= '0;
      evt_lost_q     <= 1'b0;
      run_q          <= '0;
      almfull_prev_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      age_q          <= age_d;
      outstanding_q  <= outstanding_d;
      max_latency_q  <= max_latency_d;
      err_sticky_q   <= err_sticky_d;
      evt_valid_q    <= evt_valid_d;
      evt_code_q     <= evt_code_d;
      evt_tag_q      <= evt_tag_d;
      evt_lost_q     <= evt_lost_d;
      run_q          <= run_d;
      almfull_prev_q <= almfull_prev_d;
    end
  end

  assign outstanding_o = outstanding_q;
  assign max_latency_o = max_latency_q;
  assign err_sticky_o  = err_sticky_q;
  assign evt_valid_o   = evt_valid_q;
  assign evt_code_o    = evt_code_q;
  assign evt_tag_o     = evt_tag_q;
  assign evt_lost_o    = evt_lost_q;
endmodule

// File: tb/tb_ccip_rdreq_tracker.sv
// tb/tb_ccip_rdreq_tracker.sv - scoreboard bench for ccip_rdreq_tracker with timestamp reference model
module tb_ccip_rdreq_tracker;
  localparam int TAG_W   = 4;
  localparam int LAT_W   = 7;
  localparam int TIMEOUT = 40;
  localparam int SLACK   = 8;
  localparam int NT      = 2 ** TAG_W;
  localparam int AGE_MAX = 2 ** LAT_W - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic [TAG_W:0]   outstanding_o;
  logic [LAT_W-1:0] max_latency_o;
  logic [3:0]       err_sticky_o;
  logic             evt_valid_o;
  logic [1:0]       evt_code_o;
  logic [TAG_W-1:0] evt_tag_o;
  logic             evt_lost_o;

  ccip_rdreq_tracker_if bus ();

  ccip_rdreq_tracker #(
    .TAG_W(TAG_W), .LAT_W(LAT_W), .TIMEOUT(TIMEOUT), .ALMFULL_SLACK(SLACK)
  ) dut (
    .clk_i(clk), .sys_reset_i(rst), .enable_i(enable), .c0(bus.slave),
    .outstanding_o(outstanding_o), .max_latency_o(max_latency_o),
    .err_sticky_o(err_sticky_o), .evt_valid_o(evt_valid_o),
    .evt_code_o(evt_code_o), .evt_tag_o(evt_tag_o), .evt_lost_o(evt_lost_o)
  );

  always #5 clk = ~clk;

  typedef struct {bit evt; int outst; int maxlat; int sticky; bit lost;} exp_t;
  typedef struct {int code; int tag;} evt_t;
  exp_t exp_q[$];
  evt_t evt_q[$];

  int errors = 0;
  int checks = 0;

  bit m_busy [NT];
  bit m_tod  [NT];
  int m_iss  [NT];
  int m_now, m_out, m_max, m_run, m_sticky;
  bit m_aprev, m_lost;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int age(input int t);
    int a;
    a = m_now - m_iss[t];
    return (a > AGE_MAX) ? AGE_MAX : a;
  endfunction

  task automatic model(input bit rq, input int rt, input bit rs, input int xt,
                       input bit af, input bit en, input bit r);
    exp_t s;
    evt_t e;
    bit   to_flag [NT];
    int   to_cnt, to_tag, ncause, lat;
    bit   orph, clr, dup, acc, ovr;
    s.evt = 0;
    if (r) begin
      foreach (m_busy[t]) begin m_busy[t] = 0; m_tod[t] = 0; m_iss[t] = 0; end
      m_now = 0; m_out = 0; m_max = 0; m_run = 0; m_sticky = 0; m_aprev = 0; m_lost = 0;
    end else if (en) begin
      m_now++;
      orph = rs && !m_busy[xt];
      clr  = rs && m_busy[xt];
      dup  = rq && m_busy[rt] && !(clr && xt == rt);
      acc  = rq && !dup;
      to_cnt = 0; to_tag = 0;
      for (int t = NT - 1; t >= 0; t--) begin
        to_flag[t] = m_busy[t] && !m_tod[t] && age(t) == TIMEOUT && !(clr && xt == t);
        if (to_flag[t]) begin to_cnt++; to_tag = t; end
      end
      ovr = 0;
      if (rq && m_aprev) begin m_run++; ovr = m_run > SLACK; end
      if (!af) m_run = 0;
      m_aprev = af;
      if (clr) begin
        lat = age(xt);
        if (lat > m_max) m_max = lat;
        m_busy[xt] = 0;
        m_out--;
      end
      foreach (to_flag[t]) if (to_flag[t]) m_tod[t] = 1;
      if (acc) begin m_busy[rt] = 1; m_iss[rt] = m_now; m_tod[rt] = 0; m_out++; end
      m_sticky |= (dup ? 1 : 0) | (orph ? 2 : 0) | (to_cnt > 0 ? 4 : 0) | (ovr ? 8 : 0);
      ncause = int'(orph) + int'(dup) + int'(to_cnt > 0) + int'(ovr);
      if (ncause > 1 || to_cnt > 1) m_lost = 1;
      if (ncause > 0) begin
        if (orph)            begin e.code = 1; e.tag = xt; end
        else if (dup)        begin e.code = 0; e.tag = rt; end
        else if (to_cnt > 0) begin e.code = 2; e.tag = to_tag; end
        else                 begin e.code = 3; e.tag = 0; end
        s.evt = 1;
        evt_q.push_back(e);
      end
    end
    s.outst = m_out; s.maxlat = m_max; s.sticky = m_sticky; s.lost = m_lost;
    exp_q.push_back(s);
  endtask

  task automatic step(input bit rq, input int rt, input bit rs, input int xt,
                      input bit af, input bit en, input bit r);
    logic [15:0] md;
    @(negedge clk);
    rst = r;
    enable = en;
    md = 16'($urandom);
    md[TAG_W-1:0] = rt[TAG_W-1:0];
    bus.c0_tx_mdata = md;
    bus.c0_tx_rd_valid = rq;
    md = 16'($urandom);
    md[TAG_W-1:0] = xt[TAG_W-1:0];
    bus.c0_rx_mdata = md;
    bus.c0_rx_rd_valid = rs;
    bus.c0_tx_alm_full = af;
    model(rq, rt, rs, xt, af, en, r);
  endtask

  task automatic idle(input int n, input bit af);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, af, 1, 0);
  endtask

  initial begin : monitor
    exp_t s;
    evt_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        s = exp_q.pop_front();
        chk("outstanding", int'(outstanding_o), s.outst);
        chk("max_latency", int'(max_latency_o), s.maxlat);
        chk("err_sticky", int'(err_sticky_o), s.sticky);
        chk("evt_lost", int'(evt_lost_o), int'(s.lost));
        chk("evt_valid", int'(evt_valid_o), int'(s.evt));
        if (evt_valid_o && evt_q.size() > 0) begin
          e = evt_q.pop_front();
          chk("evt_code", int'(evt_code_o), e.code);
          chk("evt_tag", int'(evt_tag_o), e.tag);
        end else if (s.evt && evt_q.size() > 0) begin
          void'(evt_q.pop_front());
        end
      end
    end
  end

  initial begin : driver
    int rt, xt, cand[$];
    bit rq, rs, af, en, r;
    bus.c0_tx_mdata = '0; bus.c0_tx_rd_valid = 0; bus.c0_tx_alm_full = 0;
    bus.c0_rx_mdata = '0; bus.c0_rx_rd_valid = 0;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1);

    // T1: 32-cycle latency, no events
    idle(5, 0);
    step(1, 5, 0, 0, 0, 1, 0);
    idle(31, 0);
    step(0, 0, 1, 5, 0, 1, 0);
    idle(1, 0);
    @(posedge clk); #2;
    chk("t1_max_latency", int'(max_latency_o), 32);
    chk("t1_outstanding", int'(outstanding_o), 0);

    // T2: duplicate tag 3
    step(1, 3, 0, 0, 0, 1, 0);
    idle(2, 0);
    step(1, 3, 0, 0, 0, 1, 0);
    idle(2, 0);
    step(0, 0, 1, 3, 0, 1, 0);

    // T3: orphan tag 9
    step(0, 0, 1, 9, 0, 1, 0);
    idle(2, 0);

    // T4: timeout of tag 1 loses to a same-cycle dup on tag 2, then late response
    step(1, 1, 0, 0, 0, 1, 0);
    step(1, 2, 0, 0, 0, 1, 0);
    idle(TIMEOUT - 2, 0);
    step(1, 2, 0, 0, 0, 1, 0);
    idle(4, 0);
    step(0, 0, 1, 1, 0, 1, 0);
    step(0, 0, 1, 2, 0, 1, 0);
    idle(2, 0);

    // T5: overrun on the ninth request under almost-full, run cleared by AlmFull drop
    step(0, 0, 0, 0, 0, 1, 1);
    idle(1, 1);
    for (int i = 0; i < 9; i++) step(1, 4 + i, 0, 0, 1, 1, 0);
    step(1, 0, 0, 0, 1, 1, 0);
    idle(1, 0);
    idle(1, 1);
    step(1, 1, 0, 0, 1, 1, 0);
    idle(1, 0);

    // T6: same-cycle response+request, reset with outstanding entries, then orphan
    step(0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(1, i, 0, 0, 0, 1, 0);
    idle(3, 0);
    step(1, 0, 1, 0, 0, 1, 0);
    idle(2, 0);
    step(0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 1, 1, 0, 1, 0);
    idle(2, 0);

    // enable low freezes ages and ignores inputs
    step(1, 7, 0, 0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, 7, 1, 9, 1, 0, 0);
    idle(3, 0);
    step(0, 0, 1, 7, 0, 1, 0);

    af = 0;
    for (int i = 0; i < 3000; i++) begin
      rq = ($urandom_range(0, 99) < 45);
      rt = $urandom_range(0, NT - 1);
      cand.delete();
      foreach (m_busy[t]) if (m_busy[t]) cand.push_back(t);
      rs = ($urandom_range(0, 99) < 35);
      if (cand.size() > 0 && $urandom_range(0, 99) < 85)
        xt = cand[$urandom_range(0, cand.size() - 1)];
      else
        xt = $urandom_range(0, NT - 1);
      if ($urandom_range(0, 14) == 0) af = !af;
      en = ($urandom_range(0, 19) != 0);
      r  = ($urandom_range(0, 499) == 0);
      step(rq, rt, rs, xt, af, en, r);
    end
    idle(3, 0);
    @(posedge clk); #2;
    chk("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
